// File: rtl/crc5_ddr_if.sv
// RX <-> CRC5 engine bus: byte strobe and re-seed in, running CRC and status out.
interface crc5_ddr_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CRC_WIDTH  = 5
);
    logic                  i_crc_clear;
    logic                  i_crc_en;
    logic                  i_crc_data_valid;
    logic [DATA_WIDTH-1:0] i_crc_data;
    logic [CRC_WIDTH-1:0]  o_crc_value;
    logic                  o_crc_valid;
    logic                  o_crc_busy;
    logic                  o_crc_overflow;

    modport master (
        output i_crc_clear, i_crc_en, i_crc_data_valid, i_crc_data,
        input  o_crc_value, o_crc_valid, o_crc_busy, o_crc_overflow
    );

    modport slave (
        input  i_crc_clear, i_crc_en, i_crc_data_valid, i_crc_data,
        output o_crc_value, o_crc_valid, o_crc_busy, o_crc_overflow
    );
endinterface

// File: rtl/crc5_ddr_engine.sv
// Bit-serial (MSB first) running CRC5 over HDR-DDR bytes, with a one-byte holding buffer.
module crc5_ddr_engine #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          CRC_WIDTH  = 5,
    parameter logic [CRC_WIDTH-1:0] POLY       = 5'b00101,
    parameter logic [CRC_WIDTH-1:0] SEED       = 5'b11111
) (
    input logic       i_sys_clk,
    input logic       i_sys_rst,
    crc5_ddr_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [CntW-1:0]       bitcnt_q, bitcnt_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  accept;
    logic                  fb;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        bitcnt_d    = bitcnt_q;
        crc_d       = crc_q;
        ovf_d       = ovf_q;
        accept      = bus.i_crc_en & bus.i_crc_data_valid;
        fb          = crc_q[CRC_WIDTH-1] ^ sr_q[DATA_WIDTH-1];

        if (bus.i_crc_clear) begin
            // A same-cycle accept becomes the first byte of the new frame.
            crc_d       = SEED;
            pend_full_d = 1'b0;
            ovf_d       = 1'b0;
            bitcnt_d    = '0;
            state_d     = StIdle;
            if (accept) begin
                sr_d    = bus.i_crc_data;
                state_d = StShift;
            end
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        sr_d     = bus.i_crc_data;
                        bitcnt_d = '0;
                        state_d  = StShift;
                    end
                end
                StShift: begin
                    crc_d    = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
                    sr_d     = {sr_q[DATA_WIDTH-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LastBit) begin
                        // The buffer drains this cycle, so an accept here never overflows.
                        bitcnt_d = '0;
                        if (pend_full_q) begin
                            sr_d        = pend_q;
                            pend_full_d = accept;
                            if (accept) pend_d = bus.i_crc_data;
                        end else if (accept) begin
                            sr_d = bus.i_crc_data;
                        end else begin
                            state_d = StDone;
                        end
                    end else if (accept) begin
                        if (pend_full_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            pend_d      = bus.i_crc_data;
                            pend_full_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        valid_d = (state_d == StDone);
        busy_d  = (state_d == StShift) | pend_full_d;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bitcnt_q    <= '0;
            crc_q       <= SEED;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bitcnt_q    <= bitcnt_d;
            crc_q       <= crc_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.o_crc_value    = crc_q;
    assign bus.o_crc_valid    = valid_q;
    assign bus.o_crc_busy     = busy_q;
    assign bus.o_crc_overflow = ovf_q;
endmodule

// File: tb/tb_crc5_ddr_engine.sv
// Directed and randomized checks of crc5_ddr_engine against a byte-level CRC5 model.
module tb_crc5_ddr_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    crc5_ddr_if bus ();

    crc5_ddr_engine dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Whole-byte CRC5 update, MSB first, x^5+x^2+1.
    function automatic logic [4:0] crc_byte(input logic [4:0] c, input logic [7:0] d);
        int r;
        int bitv;
        r = int'(c);
        for (int i = 7; i >= 0; i--) begin
            bitv = (int'(d) >> i) & 1;
            if ((((r >> 4) & 1) ^ bitv) != 0) r = ((r << 1) & 31) ^ 5;
            else r = (r << 1) & 31;
        end
        return 5'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        bus.i_crc_data_valid = 1'b1;
        bus.i_crc_data       = d;
        tick();
        bus.i_crc_data_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        bus.i_crc_clear = 1'b1;
        tick();
        bus.i_crc_clear = 1'b0;
    endtask

    logic [7:0] a, b, c;
    logic [4:0] exp_crc;
    int         n;

    initial begin
        bus.i_crc_clear      = 1'b0;
        bus.i_crc_en         = 1'b1;
        bus.i_crc_data_valid = 1'b0;
        bus.i_crc_data       = 8'h00;

        // 1: reset values
        repeat (2) tick();
        chk("rst_value", 32'(bus.o_crc_value), 32'h1F);
        chk("rst_valid", 32'(bus.o_crc_valid), 0);
        chk("rst_busy", 32'(bus.o_crc_busy), 0);
        chk("rst_ovf", 32'(bus.o_crc_overflow), 0);
        rst = 1'b1;
        tick();

        // 2: byte 00 latency and busy window
        clear_pulse();
        chk("t2_clr_valid", 32'(bus.o_crc_valid), 0);
        exp_crc = crc_byte(5'h1F, 8'h00);
        strobe(8'h00);
        for (int k = 1; k <= 8; k++) begin
            chk("t2_busy", 32'(bus.o_crc_busy), 1);
            chk("t2_valid_lo", 32'(bus.o_crc_valid), 0);
            tick();
        end
        chk("t2_valid", 32'(bus.o_crc_valid), 1);
        chk("t2_busy_lo", 32'(bus.o_crc_busy), 0);
        chk("t2_value", 32'(bus.o_crc_value), 32'h0F);
        chk("t2_model", 32'(bus.o_crc_value), 32'(exp_crc));

        // 3: byte FF, valid holds until next accept
        clear_pulse();
        strobe(8'hFF);
        repeat (8) tick();
        chk("t3_value", 32'(bus.o_crc_value), 32'h1B);
        repeat (5) begin
            tick();
            chk("t3_hold", 32'(bus.o_crc_valid), 1);
        end
        a = 8'($urandom);
        strobe(a);
        chk("t3_drop", 32'(bus.o_crc_valid), 0);
        repeat (8) tick();
        chk("t3_valid2", 32'(bus.o_crc_valid), 1);
        chk("t3_value2", 32'(bus.o_crc_value), 32'(crc_byte(5'h1B, a)));

        // 4: second byte buffered mid-shift
        clear_pulse();
        strobe(8'h00);
        repeat (2) tick();
        strobe(8'hFF);
        for (int k = 4; k <= 16; k++) begin
            chk("t4_valid_lo", 32'(bus.o_crc_valid), 0);
            chk("t4_busy", 32'(bus.o_crc_busy), 1);
            tick();
        end
        chk("t4_valid", 32'(bus.o_crc_valid), 1);
        chk("t4_value", 32'(bus.o_crc_value), 32'h15);

        // 5: overflow on third strobe, cleared by i_crc_clear
        clear_pulse();
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        strobe(a);
        strobe(b);
        strobe(c);
        chk("t5_ovf", 32'(bus.o_crc_overflow), 1);
        n = 0;
        while (!bus.o_crc_valid && n < 40) begin
            tick();
            n++;
        end
        chk("t5_wait", 32'(n), 14);
        chk("t5_value", 32'(bus.o_crc_value), 32'(crc_byte(crc_byte(5'h1F, a), b)));
        chk("t5_ovf_sticky", 32'(bus.o_crc_overflow), 1);
        clear_pulse();
        chk("t5_ovf_clr", 32'(bus.o_crc_overflow), 0);
        chk("t5_seed", 32'(bus.o_crc_value), 32'h1F);
        chk("t5_valid_clr", 32'(bus.o_crc_valid), 0);

        // 6: disabled strobe ignored; clear+strobe same cycle; async reset mid-byte
        bus.i_crc_en = 1'b0;
        strobe(8'($urandom));
        chk("t6_ign_busy", 32'(bus.o_crc_busy), 0);
        tick();
        chk("t6_ign_busy2", 32'(bus.o_crc_busy), 0);
        bus.i_crc_en         = 1'b1;
        bus.i_crc_clear      = 1'b1;
        bus.i_crc_data_valid = 1'b1;
        bus.i_crc_data       = 8'h00;
        tick();
        bus.i_crc_clear      = 1'b0;
        bus.i_crc_data_valid = 1'b0;
        chk("t6_cs_busy", 32'(bus.o_crc_busy), 1);
        repeat (8) tick();
        chk("t6_cs_valid", 32'(bus.o_crc_valid), 1);
        chk("t6_cs_value", 32'(bus.o_crc_value), 32'h0F);
        strobe(8'($urandom));
        strobe(8'($urandom));
        strobe(8'($urandom));
        tick();
        chk("t6_pre_ovf", 32'(bus.o_crc_overflow), 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_value", 32'(bus.o_crc_value), 32'h1F);
        chk("t6_rst_valid", 32'(bus.o_crc_valid), 0);
        chk("t6_rst_busy", 32'(bus.o_crc_busy), 0);
        chk("t6_rst_ovf", 32'(bus.o_crc_overflow), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_post_busy", 32'(bus.o_crc_busy), 0);
        chk("t6_post_valid", 32'(bus.o_crc_valid), 0);

        // 7: random frame, one byte every 8 cycles; en drops mid-byte
        clear_pulse();
        exp_crc = 5'h1F;
        for (int j = 0; j < 6; j++) begin
            a = 8'($urandom);
            exp_crc = crc_byte(exp_crc, a);
            strobe(a);
            bus.i_crc_en = 1'b0;
            for (int k = 1; k <= 7; k++) begin
                chk("t7_busy", 32'(bus.o_crc_busy), 1);
                chk("t7_valid_lo", 32'(bus.o_crc_valid), 0);
                bus.i_crc_data_valid = 1'($urandom_range(0, 1));
                bus.i_crc_data       = 8'($urandom);
                tick();
            end
            bus.i_crc_data_valid = 1'b0;
            bus.i_crc_en         = 1'b1;
        end
        chk("t7_last_lo", 32'(bus.o_crc_valid), 0);
        tick();
        chk("t7_valid", 32'(bus.o_crc_valid), 1);
        chk("t7_value", 32'(bus.o_crc_value), 32'(exp_crc));

        // 8: random bytes with random idle gaps
        for (int j = 0; j < 12; j++) begin
            a = 8'($urandom);
            exp_crc = crc_byte(exp_crc, a);
            strobe(a);
            repeat (8) tick();
            chk("t8_valid", 32'(bus.o_crc_valid), 1);
            chk("t8_value", 32'(bus.o_crc_value), 32'(exp_crc));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
